// File: rtl/uart_pkg.sv
// uart_pkg: shared transmitter state encoding and baud divisor helper
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  function automatic int calc_div(input int clock, input int baud);
    return clock / baud;
  endfunction
endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: byte stream handshake into the transmit FIFO
interface uart_tx_fifo_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  modport master (output in_data, output in_valid, input in_ready);
  modport slave (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count and show-ahead read data
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_count;
  logic             w_wr, w_rd;
  assign full  = r_count == (AW+1)'(DEPTH);
  assign empty = r_count == '0;
  assign count = r_count;
  assign dout  = r_mem[r_rptr];
  assign w_wr  = push && !full;
  assign w_rd  = pop && !empty;
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wptr] <= din;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= w_wr ? r_wptr + AW'(1) : r_wptr;
      r_rptr  <= w_rd ? r_rptr + AW'(1) : r_rptr;
      r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed from a byte FIFO
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLOCK = 50000000,
  parameter int BAUD  = 9600,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_tx_fifo_if.slave          s,
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
);
  localparam int DIV = calc_div(CLOCK, BAUD);
  localparam int CW  = $clog2(DIV);
  tx_state_t     r_state, w_next;
  logic [CW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx, r_busy;
  logic          w_full, w_empty, w_push, w_pop, w_tick;
  logic [7:0]    w_dout;
  assign s.in_ready = !w_full;
  assign w_push     = s.in_valid && !w_full;
  assign w_tick     = r_baud == CW'(DIV - 1);
  assign tx         = r_tx;
  assign busy       = r_busy;
  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (s.in_data),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (count)
  );
  always_ff @(posedge clk)
    r_state <= !rst ? IDLE : w_next;
  // STOP hands straight to START when another byte is waiting
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      IDLE:  begin
        w_next = w_empty ? IDLE : START;
        w_pop  = !w_empty;
      end
      START: w_next = w_tick ? DATA : START;
      DATA:  w_next = (w_tick && r_bit == 3'd7) ? STOP : DATA;
      STOP:  begin
        w_next = !w_tick ? STOP : w_empty ? IDLE : START;
        w_pop  = w_tick && !w_empty;
      end
    endcase
  end
  // tx and busy are registered from the current state, so they trail it by one clock
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_baud  <= (w_pop || w_tick) ? '0 : r_baud + CW'(1);
      r_bit   <= r_state != DATA ? '0 : r_bit + 3'(w_tick);
      r_shift <= w_pop ? w_dout : (r_state == DATA && w_tick) ? r_shift >> 1 : r_shift;
      r_tx    <= r_state == START ? 1'b0 : r_state == DATA ? r_shift[0] : 1'b1;
      r_busy  <= r_state != IDLE || !w_empty;
    end
  end
endmodule
